// File: rtl/pixel_pkg.sv
// Shared constants and helpers for the frame-buffer write path: drawer channel ids,
// default pixel width and address-width derivation.
package pixel_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 1;

    // Drawer channel assignment on the arbiter inputs; CH_FILL starts with priority.
    localparam int unsigned CH_FILL   = 0;
    localparam int unsigned CH_SYMBOL = 1;
    localparam int unsigned CH_LINE   = 2;

    function automatic int unsigned addr_width(input int unsigned hor, input int unsigned ver);
        return $clog2(hor * ver);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: rotate req by start, find first set bit,
// rotate the result back into channel numbering.
module rr_priority_select #(
    parameter int unsigned N_CHANNELS = 3,
    parameter int unsigned IDX_WIDTH  = 2
) (
    input  logic [N_CHANNELS-1:0] req,
    input  logic [IDX_WIDTH-1:0]  start,
    output logic [N_CHANNELS-1:0] grant,
    output logic [IDX_WIDTH-1:0]  idx
);

    logic [2*N_CHANNELS-1:0] doubled;
    logic [N_CHANNELS-1:0]   rotated;
    logic                    found;
    int                      pos;

    always_comb begin
        doubled = {req, req} >> start;
        rotated = doubled[N_CHANNELS-1:0];
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < int'(N_CHANNELS); k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                pos   = int'(start) + k;
                if (pos >= int'(N_CHANNELS)) begin
                    pos = pos - int'(N_CHANNELS);
                end
                idx        = IDX_WIDTH'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// N-channel round-robin arbiter with burst lock feeding one registered frame_buffer write port.
// Optional build macro PIXEL_WRITE_ARBITER_CLIP_EN drops out-of-frame writes and adds clip_error.
module pixel_write_arbiter
    import pixel_pkg::*;
#(
    parameter int unsigned N_CHANNELS        = 3,
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    localparam int unsigned PIXELS_COUNT     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int unsigned ADDR_WIDTH       = addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS),
    localparam int unsigned IDX_WIDTH        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CHANNELS-1:0]            req,
    input  logic [N_CHANNELS-1:0]            req_lock,
    input  logic [N_CHANNELS*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] req_data,
    output logic [N_CHANNELS-1:0]            grant,
    output logic                             write_enable,
    output logic [ADDR_WIDTH-1:0]            write_addr,
    output logic [DATA_WIDTH-1:0]            write_data,
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    output logic                             clip_error,
`endif
    output logic                             busy
);

    logic [IDX_WIDTH-1:0]  rr_ptr_q;
    logic [IDX_WIDTH-1:0]  lock_owner_q;
    logic                  lock_valid_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic [N_CHANNELS-1:0] rr_grant;
    logic [IDX_WIDTH-1:0]  rr_idx;
    logic                  owner_hit;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic [IDX_WIDTH-1:0]  rr_ptr_next;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_priority_select #(
        .N_CHANNELS (N_CHANNELS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_select (
        .req   (req),
        .start (rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // A held lock only wins while its owner keeps requesting; otherwise fall back at once.
    assign owner_hit = lock_valid_q && req[lock_owner_q];

    always_comb begin
        grant     = '0;
        grant_idx = rr_idx;
        if (owner_hit) begin
            grant_idx = lock_owner_q;
            grant     = N_CHANNELS'(1) << lock_owner_q;
        end else begin
            grant = rr_grant;
        end
        if (rst) begin
            grant = '0;
        end
    end

    assign accept      = |grant;
    assign rr_ptr_next = (grant_idx == IDX_WIDTH'(N_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    assign sel_addr    = req_addr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data    = req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    logic clip_q;
    logic in_range;

    // Extra bit keeps the compare correct when PIXELS_COUNT is an exact power of two.
    assign in_range   = {1'b0, sel_addr} < (ADDR_WIDTH + 1)'(PIXELS_COUNT);
    assign clip_error = clip_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            lock_valid_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
            clip_q       <= 1'b0;
`endif
        end else if (accept) begin
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
            we_q <= in_range;
            if (in_range) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
            end else begin
                clip_q <= 1'b1;
            end
`else
            we_q   <= 1'b1;
            addr_q <= sel_addr;
            data_q <= sel_data;
`endif
            if (req_lock[grant_idx]) begin
                lock_owner_q <= grant_idx;
                lock_valid_q <= 1'b1;
            end else begin
                lock_valid_q <= 1'b0;
                rr_ptr_q     <= rr_ptr_next;
            end
        end else begin
            // No accept means no requests at all, so any lock owner has let go.
            we_q         <= 1'b0;
            lock_valid_q <= 1'b0;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign busy         = (|req) | we_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed self-checking bench for pixel_write_arbiter (3 channels, 640x480, 1 bit per pixel).
module tb_pixel_write_arbiter;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 19;
    localparam int unsigned DW  = 1;

    logic                clk;
    logic                rst;
    logic [NCH-1:0]      req;
    logic [NCH-1:0]      req_lock;
    logic [NCH*AW-1:0]   req_addr;
    logic [NCH*DW-1:0]   req_data;
    logic [NCH-1:0]      grant;
    logic                write_enable;
    logic [AW-1:0]       write_addr;
    logic [DW-1:0]       write_data;
    logic                busy;
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    logic                clip_error;
`endif

    int vectors;
    int miscompares;

    pixel_write_arbiter #(
        .N_CHANNELS        (NCH),
        .HOR_ACTIVE_PIXELS (640),
        .VER_ACTIVE_PIXELS (480),
        .DATA_WIDTH        (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .grant        (grant),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
        .clip_error   (clip_error),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic d);
        req_addr[ch*AW +: AW] = a;
        req_data[ch*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_lock = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = 3'b111;
        req_lock = '0;
        #1;
        vectors++;
        if (grant !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_grant: got %b want 000", grant);
        end
        tick();
        tick();
        req = '0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (grant !== 3'b000 || write_enable !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_cycle%0d: grant=%b we=%b busy=%b want 000/0/0",
                         c, grant, write_enable, busy);
            end
            tick();
        end
        vectors++;
        if (write_addr !== 19'd0 || write_data !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: addr=%0d data=%b want 0/0", write_addr, write_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_ch(1, 19'd1000, 1'b1);
        req = 3'b010;
        #1;
        vectors++;
        if (grant !== 3'b010 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: grant=%b busy=%b want 010/1", grant, busy);
        end
        tick();
        req = '0;
        #1;
        vectors++;
        if (write_enable !== 1'b1 || write_addr !== 19'd1000 || write_data !== 1'b1) begin
            miscompares++;
            $display("FAIL single_write: we=%b addr=%0d data=%b want 1/1000/1",
                     write_enable, write_addr, write_data);
        end
        tick();
        vectors++;
        if (write_enable !== 1'b0 || write_addr !== 19'd1000) begin
            miscompares++;
            $display("FAIL single_after: we=%b addr=%0d want 0/1000 (held)",
                     write_enable, write_addr);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [3];
        logic [2:0] dpat;
        exp_g[0] = 3'b001;
        exp_g[1] = 3'b010;
        exp_g[2] = 3'b100;
        dpat     = 3'b101;
        do_reset();
        for (int i = 0; i < 3; i++) set_ch(i, 19'(100 + i), dpat[i]);
        req = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (grant !== exp_g[k % 3]) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b want %b", k, grant, exp_g[k % 3]);
            end
            if (k > 0) begin
                vectors++;
                if (write_enable !== 1'b1 || write_addr !== 19'(100 + (k - 1) % 3) ||
                    write_data !== dpat[(k - 1) % 3]) begin
                    miscompares++;
                    $display("FAIL rr_write%0d: we=%b addr=%0d data=%b want 1/%0d/%b", k,
                             write_enable, write_addr, write_data, 100 + (k - 1) % 3,
                             dpat[(k - 1) % 3]);
                end
            end
            tick();
        end
        req = '0;
        #1;
        vectors++;
        if (write_enable !== 1'b1 || write_addr !== 19'd102 || write_data !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_last: we=%b addr=%0d data=%b want 1/102/1",
                     write_enable, write_addr, write_data);
        end
        tick();
        vectors++;
        if (write_enable !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_drain: we=%b busy=%b want 0/0", write_enable, busy);
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        set_ch(0, 19'd5, 1'b1);
        set_ch(2, 19'd7, 1'b0);
        req      = 3'b101;
        req_lock = 3'b101;  // ch2 also asks for a lock; the ch0 lock must win
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (grant !== 3'b001) begin
                miscompares++;
                $display("FAIL lock_grant%0d: got %b want 001", k, grant);
            end
            tick();
        end
        req      = 3'b100;
        req_lock = 3'b000;
        #1;
        vectors++;
        if (grant !== 3'b100 || write_addr !== 19'd5) begin
            miscompares++;
            $display("FAIL lock_release: grant=%b addr=%0d want 100/5", grant, write_addr);
        end
        tick();
        req = 3'b111;
        #1;
        vectors++;
        if (grant !== 3'b001 || write_addr !== 19'd7) begin
            miscompares++;
            $display("FAIL lock_ptr_wrap: grant=%b addr=%0d want 001/7", grant, write_addr);
        end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_ch(1, 19'd42, 1'b1);
        req      = 3'b011;
        req_lock = 3'b010;
        tick();  // ch0 wins first, pointer moves to ch1
        tick();  // ch1 accepted with lock
        #1;
        vectors++;
        if (grant !== 3'b010) begin
            miscompares++;
            $display("FAIL midrst_locked: grant=%b want 010", grant);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (grant !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_grant: grant=%b want 000", grant);
        end
        tick();
        rst      = 1'b0;
        req      = 3'b111;
        req_lock = 3'b000;
        #1;
        vectors++;
        if (write_enable !== 1'b0 || grant !== 3'b001) begin
            miscompares++;
            $display("FAIL midrst_after: we=%b grant=%b want 0/001", write_enable, grant);
        end
        tick();
        req = '0;
        tick();
    endtask

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    task automatic test_clip();
        do_reset();
        set_ch(0, 19'd307200, 1'b1);
        req = 3'b001;
        #1;
        vectors++;
        if (grant !== 3'b001) begin
            miscompares++;
            $display("FAIL clip_grant: got %b want 001", grant);
        end
        tick();
        set_ch(0, 19'd307199, 1'b1);
        #1;
        vectors++;
        if (write_enable !== 1'b0 || clip_error !== 1'b1) begin
            miscompares++;
            $display("FAIL clip_drop: we=%b clip=%b want 0/1", write_enable, clip_error);
        end
        tick();
        req = '0;
        #1;
        vectors++;
        if (write_enable !== 1'b1 || write_addr !== 19'd307199 || clip_error !== 1'b1) begin
            miscompares++;
            $display("FAIL clip_inrange: we=%b addr=%0d clip=%b want 1/307199/1",
                     write_enable, write_addr, clip_error);
        end
        do_reset();
        vectors++;
        if (clip_error !== 1'b0) begin
            miscompares++;
            $display("FAIL clip_clear: clip=%b want 0", clip_error);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = '0;
        req_lock    = '0;
        req_addr    = '0;
        req_data    = '0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_reset_mid_burst();
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
        test_clip();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
